// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues in-order imem requests, buffers the returned
// opcodes with their PCs and drops stale responses after a redirect.
module fetch_unit #(
  parameter int unsigned      Width   = 32,
  parameter int unsigned      Depth   = 4,
  parameter logic [Width-1:0] ResetPc = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [Width-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [Width-1:0] imem_rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_pc,
  output logic [Width-1:0] out_opcode
);

  localparam int unsigned      CntW = $clog2(Depth + 1);
  localparam int unsigned      PtrW = $clog2(Depth);
  localparam logic [Width-1:0] Nop  = Width'(32'h0000_0013);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [Width-1:0]  fetch_pc_q, fetch_pc_d;
  logic [Width-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CntW-1:0]   outstanding_q, outstanding_d;
  logic [CntW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [Width-1:0]  pc_mem_q [Depth];
  logic [Width-1:0]  op_mem_q [Depth];

  logic [CntW:0]     in_use;
  logic              req_fire;
  logic              push;
  logic              pop;

  // Credit check covers both in-flight and buffered fetches, so the queue never overflows.
  assign in_use         = {1'b0, outstanding_q} + {1'b0, count_q};
  assign imem_req_valid = rst && !halt && !redirect_valid && (in_use < (CntW + 1)'(Depth));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid  = (count_q != '0) && !redirect_valid;
  assign out_pc     = out_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign out_opcode = out_valid ? op_mem_q[rd_ptr_q] : Nop;

  assign pop  = out_valid && out_ready;
  assign push = imem_rsp_valid && (state_q == StRun) && !redirect_valid;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + Width'(4);
    end

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      // A response landing in the redirect cycle is already stale.
      drop_cnt_d = outstanding_q - CntW'(imem_rsp_valid);
      state_d    = (drop_cnt_d != '0) ? StFlush : StRun;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rsp_pc_d = rsp_pc_q + Width'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
      if ((state_q == StFlush) && imem_rsp_valid) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
        if (drop_cnt_q == CntW'(1)) begin
          state_d = StRun;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StRun;
      fetch_pc_q    <= ResetPc;
      rsp_pc_q      <= ResetPc;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q] <= rsp_pc_q;
      op_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count_q == CntW'(Depth))));

  a_no_spurious_rsp: assert property (@(posedge clk) disable iff (!rst)
    !(imem_rsp_valid && (outstanding_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a latency-configurable memory plus a queue-based reference model
// predicting every output each cycle, with directed scenarios and a random soak.
module tb_fetch_unit;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_opcode;

  fetch_unit #(.Width(32), .Depth(Depth), .ResetPc(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_opcode     (out_opcode)
  );

  always #5 clk = ~clk;

  typedef struct {logic [31:0] pc; bit stale;} infl_t;
  typedef struct {logic [31:0] pc; logic [31:0] op;} ent_t;
  typedef struct {logic [31:0] addr; int due;} pend_t;

  int          checks;
  int          failures;
  int          cyc;
  int          lat;
  infl_t       infl[$];
  ent_t        mq[$];
  pend_t       pend[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] popped_pc[$];
  logic [31:0] popped_op[$];
  logic [31:0] acc_addr[$];
  bit          last_ov;

  function automatic logic [31:0] op_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock cycle: memory drives its response, outputs are compared at the negedge,
  // then model and memory advance as the DUT will at the next posedge.
  task automatic step();
    bit          e_req, e_ov, acc, rsp;
    logic [31:0] e_pc, e_op, rdata;
    infl_t       ent;
    pend_t       p;
    rsp = (pend.size() > 0) && (pend[0].due <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? op_of(pend[0].addr) : 32'h0;
    rdata = imem_rsp_data;
    @(negedge clk);
    e_req = !halt && !redirect_valid && ((infl.size() + mq.size()) < Depth);
    e_ov  = (mq.size() > 0) && !redirect_valid;
    e_pc  = e_ov ? mq[0].pc : 32'h0;
    e_op  = e_ov ? mq[0].op : Nop;
    checks++;
    if (imem_req_valid !== e_req) begin
      failures++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, e_req);
    end
    if (e_req) begin
      checks++;
      if (imem_addr !== m_fetch_pc) begin
        failures++;
        $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch_pc);
      end
    end
    checks++;
    if (out_valid !== e_ov) begin
      failures++;
      $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, e_ov);
    end
    checks++;
    if (out_pc !== e_pc) begin
      failures++;
      $display("FAIL out_pc cyc=%0d got=%h exp=%h", cyc, out_pc, e_pc);
    end
    checks++;
    if (out_opcode !== e_op) begin
      failures++;
      $display("FAIL out_opcode cyc=%0d got=%h exp=%h", cyc, out_opcode, e_op);
    end
    last_ov = out_valid;
    if (out_valid === 1'b1 && out_ready) begin
      popped_pc.push_back(out_pc);
      popped_op.push_back(out_opcode);
    end
    if (imem_req_valid === 1'b1 && imem_req_ready) acc_addr.push_back(imem_addr);

    acc = e_req && imem_req_ready;
    if (rsp) void'(pend.pop_front());
    if (acc) begin
      p.addr = m_fetch_pc;
      p.due  = cyc + lat;
      if (pend.size() > 0 && pend[$].due >= p.due) p.due = pend[$].due + 1;
      pend.push_back(p);
    end
    ent.pc = 32'h0;
    ent.stale = 1'b1;
    if (rsp && infl.size() > 0) ent = infl.pop_front();
    if (redirect_valid) begin
      mq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      m_fetch_pc = redirect_pc;
    end else begin
      if (acc) begin
        infl.push_back('{pc: m_fetch_pc, stale: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      if (e_ov && out_ready) void'(mq.pop_front());
      if (rsp && !ent.stale) mq.push_back('{pc: ent.pc, op: rdata});
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset at the current time, checks outputs while held, releases after two edges.
  task automatic do_reset();
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    halt           = 1'b0;
    out_ready      = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valids req=%b out=%b exp=0/0", imem_req_valid, out_valid);
    end
    checks++;
    if (out_pc !== 32'h0 || out_opcode !== Nop) begin
      failures++;
      $display("FAIL reset_outputs pc=%h op=%h exp=0/%h", out_pc, out_opcode, Nop);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    infl.delete();
    mq.delete();
    pend.delete();
    popped_pc.delete();
    popped_op.delete();
    acc_addr.delete();
    m_fetch_pc = 32'h0;
    cyc = 0;
    lat = 1;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    checks++;
    if (popped_pc.size() != 10) begin
      failures++;
      $display("FAIL stream_count got=%0d exp=10", popped_pc.size());
    end
    for (int i = 0; i < popped_pc.size() && i < 10; i++) begin
      checks++;
      if (popped_pc[i] !== 32'(4 * i) || popped_op[i] !== op_of(32'(4 * i))) begin
        failures++;
        $display("FAIL stream_seq idx=%0d got=%h exp=%h", i, popped_pc[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    checks++;
    if (acc_addr.size() != 4 || acc_addr[3] !== 32'hC) begin
      failures++;
      $display("FAIL bp_accepts got=%0d exp=4", acc_addr.size());
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    for (int i = 0; i < 5; i++) begin
      exp_pc = 32'(4 * i);
      checks++;
      if (popped_pc.size() <= i || popped_pc[i] !== exp_pc) begin
        failures++;
        $display("FAIL bp_drain idx=%0d got=%h exp=%h", i,
                 (popped_pc.size() > i) ? popped_pc[i] : 32'hx, exp_pc);
      end
    end
  endtask

  task automatic test_redirect_latency();
    do_reset();
    lat = 3;
    for (int i = 0; i < 2; i++) step();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    for (int i = 0; i < 15; i++) step();
    checks++;
    if (popped_pc.size() == 0 || popped_pc[0] !== 32'h100 || popped_op[0] !== op_of(32'h100))
    begin
      failures++;
      $display("FAIL redir_first got=%h exp=%h",
               (popped_pc.size() > 0) ? popped_pc[0] : 32'hx, 32'h100);
    end
  endtask

  task automatic test_redirect_rsp();
    int n;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    n = popped_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (popped_pc.size() != n || last_ov !== 1'b0) begin
      failures++;
      $display("FAIL redir_rsp_nopop pops=%0d exp=%0d ov=%b", popped_pc.size(), n, last_ov);
    end
    step();
    checks++;
    if (last_ov !== 1'b0) begin
      failures++;
      $display("FAIL redir_rsp_empty out_valid=%b exp=0", last_ov);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (popped_pc.size() <= n || popped_pc[n] !== 32'h200) begin
      failures++;
      $display("FAIL redir_rsp_target got=%h exp=200",
               (popped_pc.size() > n) ? popped_pc[n] : 32'hx);
    end
  endtask

  task automatic test_halt();
    int a0;
    do_reset();
    lat = 2;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && m_fetch_pc != 32'h20; i++) step();
    checks++;
    if (acc_addr.size() == 0 || acc_addr[$] !== 32'h1C) begin
      failures++;
      $display("FAIL halt_setup last_addr=%h exp=1c",
               (acc_addr.size() > 0) ? acc_addr[$] : 32'hx);
    end
    a0 = acc_addr.size();
    halt = 1'b1;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (acc_addr.size() != a0) begin
      failures++;
      $display("FAIL halt_noreq accepts=%0d exp=%0d", acc_addr.size(), a0);
    end
    checks++;
    if (popped_pc.size() < 2 || popped_pc[$-1] !== 32'h18 || popped_pc[$] !== 32'h1C) begin
      failures++;
      $display("FAIL halt_drain last=%h exp=1c", (popped_pc.size() > 0) ? popped_pc[$] : 32'hx);
    end
    halt = 1'b0;
    step();
    checks++;
    if (acc_addr.size() != a0 + 1 || acc_addr[$] !== 32'h20) begin
      failures++;
      $display("FAIL halt_resume addr=%h exp=20", (acc_addr.size() > 0) ? acc_addr[$] : 32'hx);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (out_valid !== 1'b1 || imem_req_valid !== 1'b0 || acc_addr.size() != 4) begin
      failures++;
      $display("FAIL rstmid_full out_valid=%b req=%b acc=%0d exp=1/0/4",
               out_valid, imem_req_valid, acc_addr.size());
    end
    #2;
    do_reset();
    step();
    checks++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_first addr=%h exp=0", (acc_addr.size() > 0) ? acc_addr[0] : 32'hx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 0) lat = $urandom_range(1, 4);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 24) == 0) halt = ~halt;
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      step();
    end
    redirect_valid = 1'b0;
    halt = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_redirect_rsp();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end sitting directly upstream of stage_if and the IF/ID pipeline register.
- Owns the architectural fetch PC and issues in-order requests to instruction memory over a valid/ready request channel, which may have variable latency.
- Buffers returned opcodes with their PCs in a small prefetch queue and presents them to the decode side with a valid/ready handshake.
- Handles branch redirects from EX by flushing the queue and discarding in-flight responses.

Parameters:
- Width, 32, data/address width (equals rvcpu::Width).
- Depth, 4, prefetch queue entries; also the cap on outstanding plus buffered fetches (power of two, ≥2).
- ResetPc, 0, fetch address after reset (equals rvcpu::RESET_PC).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-low (asserted when 0).
- halt  input  1  stop issuing new requests (WFI / invalid decode); queue still drains.
- redirect_valid  input  1  branch taken in EX this cycle.
- redirect_pc  input  Width  branch target.
- imem_req_valid  output  1  request present.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  Width  request address.
- imem_rsp_valid  input  1  response present; in order, one per accepted request, always accepted.
- imem_rsp_data  input  Width  returned opcode.
- out_valid  output  1  instruction available to IF/ID.
- out_ready  input  1  IF/ID accepts (low when stall_if).
- out_pc  output  Width  PC of head instruction.
- out_opcode  output  Width  opcode of head instruction.

Behaviour:
- Reset (rst=0, async): fetch_pc=ResetPc, rsp_pc=ResetPc, queue empty, outstanding=0, drop_cnt=0, state=RUN. Outputs during reset: imem_req_valid=0, out_valid=0, out_pc=0, out_opcode=rvcpu::NOP (0x00000013).
- Counters are $clog2(Depth+1) bits wide; credit invariant: outstanding + count ≤ Depth.
- Request: imem_req_valid = !halt && !redirect_valid && (outstanding + count < Depth); imem_addr = fetch_pc.
  - On a request handshake, fetch_pc += 4 (wraps modulo 2^Width) and outstanding increments.
- Response: every imem_rsp_valid decrements outstanding.
  - State RUN: push {rsp_pc, imem_rsp_data} into the queue; rsp_pc += 4.
  - State FLUSH: discard the response and decrement drop_cnt; when drop_cnt reaches 1→0, go to RUN.
- Output is driven combinationally from the queue head.
  - out_valid = count>0 && !redirect_valid.
  - When out_valid=0, out_pc=0 and out_opcode=NOP.
  - On a pop handshake (out_valid && out_ready), the head is removed.
  - Push and pop may occur in the same cycle, including when count==Depth−1 or count==Depth. The credit rule makes overflow impossible; a push into a full queue is an assertion failure.
- Latency: a request accepted at cycle N with its response at cycle N+k produces out_valid at N+k+1 at the earliest (registered queue, no bypass).
- Redirect (redirect_valid=1):
  - Same cycle: no request issued, no pop, out_valid=0.
  - Next edge: queue cleared, fetch_pc=rsp_pc=redirect_pc.
  - drop_cnt = outstanding − (imem_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is itself discarded.
  - State becomes FLUSH if drop_cnt>0, else RUN.
  - A redirect during FLUSH recomputes drop_cnt the same way (drop_cnt tracks all stale in-flight fetches).
  - New requests may issue during FLUSH; their responses arrive after the stale ones.
- halt: gates new requests only. Outstanding responses are still buffered and drained. Deasserting halt resumes at fetch_pc.
- Reset mid-operation: all state returns to reset values immediately. Responses from before reset must not arrive after it (memory is reset together).

Test Plan:
- Zero-wait memory (ready=1, response 1 cycle later), out_ready=1 from reset → out_pc sequence 0x0, 0x4, 0x8, ... with one instruction per cycle after a 2-cycle startup; imem_addr stays one entry ahead.
- out_ready=0 held → exactly Depth=4 requests accepted (addresses 0x0–0xC), then imem_req_valid=0. Release out_ready → drains in order 0x0, 0x4, 0x8, 0xC, then fetching resumes at 0x10.
- Memory latency 3 cycles with 2 requests outstanding, redirect to 0x100 → next two responses dropped; first out_valid shows out_pc=0x100 with the opcode returned for address 0x100.
- Redirect coinciding with a response and with out_ready=1 → that response is discarded, no pop occurs, out_valid=0 that cycle, and the queue is empty the next cycle.
- halt=1 at fetch_pc=0x20 with 2 outstanding → both buffered and delivered (0x18, 0x1C), no further requests; halt=0 → request at 0x20.
- rst pulsed low asynchronously mid-stream with the queue full → out_valid=0 and imem_req_valid=0 immediately; after release, first imem_addr=ResetPc.
